tblink_rpc_invoke_sched: RTL and testbench
==========================================

// Module: tblink_rpc_invoke_sched
// PURPOSE
//  Shares one outbound TbLink RPC invoke channel (toward the DPI endpoint shim) among N_REQ BFM requesters.
//  Round-robin arbitration; allocates a call_id per invoke; tracks one outstanding blocking call per requester.
//  Routes each invoke_rsp back to its requester by call_id.
//  Non-blocking invokes are issued and retired at accept; they get no response tracking.
// PARAMETERS
//  N_REQ     4   number of requesters (2..16)
//  METHOD_W  16  method-id width
//  DATA_W    64  packed param/return payload width
//  ID_W      8   call_id width; must satisfy ID_W > $clog2(N_REQ)
// PORTS
//  clock         in   1               single clock; all logic rising-edge
//  reset         in   1               synchronous, active-high
//  req_valid     in   N_REQ           per-requester invoke request
//  req_ready     out  N_REQ           one-hot pulse: request captured
//  req_blocking  in   N_REQ           1 = blocking (expects response)
//  req_method    in   N_REQ*METHOD_W  method id, requester i at slice i
//  req_params    in   N_REQ*DATA_W    params, requester i at slice i
//  out_valid     out  1               invoke to endpoint valid
//  out_ready     in   1               endpoint accepts invoke
//  out_ifinst    out  $clog2(N_REQ)   requester index
//  out_method    out  METHOD_W        method id
//  out_call_id   out  ID_W            allocated call_id
//  out_params    out  DATA_W          params
//  rsp_valid     in   1               invoke_rsp from endpoint (no backpressure)
//  rsp_call_id   in   ID_W            call_id being answered
//  rsp_data      in   DATA_W          return value
//  done_valid    out  N_REQ           one-hot pulse: blocking call retired
//  done_data     out  DATA_W          return value, qualified by done_valid
//  busy          out  N_REQ           requester has a blocking call outstanding
//  err_unknown   out  1               pulse: rsp_call_id matches no outstanding call
// BEHAVIOUR
//  Reset: out_valid, req_ready, done_valid, busy and err_unknown are 0; call counter = 0; RR pointer = 0.
//  Reset: table cleared, FSM enters IDLE. Reset mid-operation drops all in-flight calls.
//  Eligibility: eligible[i] = req_valid[i] & ~busy[i], using registered busy.
//  FSM IDLE: if any requester is eligible, the RR winner is the first eligible index after the last grant.
//   - Winner request is captured into out_* regs.
//   - req_ready[winner] pulses for 1 cycle.
//   - call_id = counter; FSM moves to ISSUE.
//  FSM ISSUE: out_valid=1 and out_* are held stable until out_ready; on accept, FSM returns to IDLE.
//   - Accept of a blocking call sets busy[idx] and table[idx].id = call_id.
//   - Latency: req_valid to out_valid is 1 cycle minimum. Back-to-back issue is every 2 cycles.
//  Call-id allocation: counter increments by 1 per capture and wraps modulo 2^ID_W.
//   - If counter equals any busy entry's id, IDLE does not capture that cycle; counter increments and capture retries next cycle.
//  Response: rsp_valid with id == table[i].id && busy[i] produces, next cycle:
//   - done_valid[i]=1 and done_data=rsp_data
//   - busy[i] cleared at the same edge
//  No match: err_unknown pulses next cycle and the response is dropped. This covers stale ids after reset and non-blocking ids.
//  Simultaneous rsp retiring requester i and IDLE evaluation: i is not eligible until the cycle after busy clears (registered busy).
//  Simultaneous rsp and out accept: both take effect. The new id cannot equal the responding id (collision rule).
//  req_valid deasserting while in ISSUE has no effect; the captured call still issues.
// STRUCTURE
//  Package tblink_rpc_hdl_pkg holds:
//   - typedef invoke_req_t {method, params, blocking}
//   - typedef call_ent_t {busy, id}
//   - enum sched_state_e {IDLE, ISSUE}
//  Sub-module tblink_rpc_rr_arb: N-way round-robin arbiter.
//   - Inputs: eligible vector, advance strobe.
//   - Output: one-hot grant plus index.
//   - Pointer updates only on advance.
// TESTING
//  1. Single blocking call: req 0 method=0x12 params=5; out_ready=1.
//     -> out_valid at cycle+1 with call_id=0 and ifinst=0.
//     -> rsp id=0 data=0xAB gives done_valid=0001 and done_data=0xAB; busy[0] clears.
//  2. All 4 requesters request, blocking, every cycle; responses returned immediately.
//     -> grant order 0,1,2,3,0; call_ids 0,1,2,3,4.
//  3. Requester 1 busy while re-requesting.
//     -> no second issue for 1 until its done_valid; other requesters are still served.
//  4. Non-blocking req from 2, then rsp with that id.
//     -> busy stays 0, no done_valid, err_unknown pulses once.
//  5. Counter at 255 with call id 0 outstanding.
//     -> id 255 issues, 0 is skipped (1 stall cycle), next issue uses id 1.
//  6. Reset asserted during ISSUE with 2 calls outstanding.
//     -> out_valid=0 next cycle, busy=0; later rsp for an old id gives err_unknown.

Source files
------------

// File: rtl/tblink_rpc_hdl_pkg.sv
// Shared types for the TbLink RPC invoke scheduler: request/table record
// layouts at the default widths and the scheduler FSM state encoding.
package tblink_rpc_hdl_pkg;

   localparam int PKG_METHOD_W = 16;
   localparam int PKG_DATA_W   = 64;
   localparam int PKG_ID_W     = 8;

   // One captured invoke request (default widths).
   typedef struct packed {
      logic [PKG_METHOD_W-1:0] method;
      logic [PKG_DATA_W-1:0]   params;
      logic                    blocking;
   } invoke_req_t;

   // One call-table entry: outstanding flag plus the call_id it waits on.
   typedef struct packed {
      logic                busy;
      logic [PKG_ID_W-1:0] id;
   } call_ent_t;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ISSUE = 1'b1
   } sched_state_e;

endpackage

// File: rtl/tblink_rpc_rr_arb.sv
// N-way round-robin arbiter. The search starts at the index after the last
// grant; the pointer moves only when the caller consumes the grant.
module tblink_rpc_rr_arb #(
   parameter int N_REQ = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         eligible,
   input  logic                     advance,
   output logic [N_REQ-1:0]         grant,
   output logic [$clog2(N_REQ)-1:0] grant_idx,
   output logic                     any
);

   localparam int IDX_W = $clog2(N_REQ);

   logic [IDX_W-1:0] ptr_r;
   logic             found_s;

   assign any = |eligible;

   // Pick the first eligible index at or after the priority pointer.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found_s   = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found_s && eligible[(int'(ptr_r) + k) % N_REQ]) begin
            found_s                             = 1'b1;
            grant[(int'(ptr_r) + k) % N_REQ]    = 1'b1;
            grant_idx                           = IDX_W'((int'(ptr_r) + k) % N_REQ);
         end else begin
            found_s = found_s;
         end
      end
   end

   // Priority pointer: one past the consumed grant, wrapping at N_REQ.
   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_r <= '0;
      end else if (advance) begin
         if (grant_idx == IDX_W'(N_REQ - 1)) begin
            ptr_r <= '0;
         end else begin
            ptr_r <= grant_idx + IDX_W'(1'b1);
         end
      end else begin
         ptr_r <= ptr_r;
      end
   end

endmodule

// File: rtl/tblink_rpc_invoke_sched.sv
// Shares one outbound TbLink RPC invoke channel among N_REQ requesters.
// Round-robin capture, call_id allocation that skips ids still in use,
// one outstanding blocking call per requester, responses routed by call_id.
module tblink_rpc_invoke_sched
   import tblink_rpc_hdl_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int METHOD_W = PKG_METHOD_W,
   parameter int DATA_W   = PKG_DATA_W,
   parameter int ID_W     = PKG_ID_W
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          req_valid,
   output logic [N_REQ-1:0]          req_ready,
   input  logic [N_REQ-1:0]          req_blocking,
   input  logic [N_REQ*METHOD_W-1:0] req_method,
   input  logic [N_REQ*DATA_W-1:0]   req_params,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [$clog2(N_REQ)-1:0]  out_ifinst,
   output logic [METHOD_W-1:0]       out_method,
   output logic [ID_W-1:0]           out_call_id,
   output logic [DATA_W-1:0]         out_params,
   input  logic                      rsp_valid,
   input  logic [ID_W-1:0]           rsp_call_id,
   input  logic [DATA_W-1:0]         rsp_data,
   output logic [N_REQ-1:0]          done_valid,
   output logic [DATA_W-1:0]         done_data,
   output logic [N_REQ-1:0]          busy,
   output logic                      err_unknown
);

   localparam int IDX_W = $clog2(N_REQ);

   logic [METHOD_W-1:0] method_a [N_REQ];
   logic [DATA_W-1:0]   params_a [N_REQ];

   sched_state_e        state_r, state_s;
   logic [N_REQ-1:0]    eligible_s, grant_s, cnt_hit_s, rsp_hit_s;
   logic [IDX_W-1:0]    grant_idx_s;
   logic                grant_any_s, collide_s, capture_s, bump_s, accept_s;

   logic [ID_W-1:0]     cnt_r;
   logic [N_REQ-1:0]    busy_r;
   logic [ID_W-1:0]     id_r [N_REQ];

   logic                out_valid_r, out_blocking_r;
   logic [IDX_W-1:0]    out_ifinst_r;
   logic [METHOD_W-1:0] out_method_r;
   logic [ID_W-1:0]     out_call_id_r;
   logic [DATA_W-1:0]   out_params_r;
   logic [N_REQ-1:0]    req_ready_r, done_valid_r;
   logic [DATA_W-1:0]   done_data_r;
   logic                err_unknown_r;

   // Per-requester views of the packed request buses and table compares.
   for (genvar g = 0; g < N_REQ; g++) begin : g_ent
      assign method_a[g]  = req_method[g*METHOD_W +: METHOD_W];
      assign params_a[g]  = req_params[g*DATA_W +: DATA_W];
      assign cnt_hit_s[g] = busy_r[g] & (id_r[g] == cnt_r);
      assign rsp_hit_s[g] = rsp_valid & busy_r[g] & (id_r[g] == rsp_call_id);
   end

   // A requester with a call in flight is not offered to the arbiter.
   assign eligible_s = req_valid & ~busy_r;
   assign collide_s  = |cnt_hit_s;

   tblink_rpc_rr_arb #(
      .N_REQ (N_REQ)
   ) u_arb (
      .clock     (clock),
      .reset     (reset),
      .eligible  (eligible_s),
      .advance   (capture_s),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .any       (grant_any_s)
   );

   // Next-state and strobes: capture in IDLE unless the counter hits a live id.
   always_comb begin
      state_s   = state_r;
      capture_s = 1'b0;
      bump_s    = 1'b0;
      accept_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (grant_any_s) begin
               bump_s = 1'b1;
               if (!collide_s) begin
                  capture_s = 1'b1;
                  state_s   = ISSUE;
               end else begin
                  capture_s = 1'b0;
               end
            end else begin
               bump_s = 1'b0;
            end
         end
         ISSUE: begin
            if (out_ready) begin
               accept_s = 1'b1;
               state_s  = IDLE;
            end else begin
               accept_s = 1'b0;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Call-id counter and the captured invoke held on the out_* channel.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_r          <= '0;
         out_valid_r    <= 1'b0;
         out_blocking_r <= 1'b0;
         out_ifinst_r   <= '0;
         out_method_r   <= '0;
         out_call_id_r  <= '0;
         out_params_r   <= '0;
         req_ready_r    <= '0;
      end else begin
         req_ready_r <= '0;
         if (bump_s) begin
            cnt_r <= cnt_r + ID_W'(1'b1);
         end else begin
            cnt_r <= cnt_r;
         end
         if (capture_s) begin
            out_valid_r    <= 1'b1;
            out_blocking_r <= req_blocking[grant_idx_s];
            out_ifinst_r   <= grant_idx_s;
            out_method_r   <= method_a[grant_idx_s];
            out_call_id_r  <= cnt_r;
            out_params_r   <= params_a[grant_idx_s];
            req_ready_r    <= grant_s;
         end else if (accept_s) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
      end
   end

   // Call table: accepted blocking calls become busy; matching responses retire them.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < N_REQ; i++) begin
            busy_r[i] <= 1'b0;
            id_r[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (accept_s && out_blocking_r && (out_ifinst_r == IDX_W'(i))) begin
               busy_r[i] <= 1'b1;
               id_r[i]   <= out_call_id_r;
            end else if (rsp_hit_s[i]) begin
               busy_r[i] <= 1'b0;
            end else begin
               busy_r[i] <= busy_r[i];
            end
         end
      end
   end

   // Response routing: done pulse to the owner, or an error pulse on a miss.
   always_ff @(posedge clock) begin
      if (reset) begin
         done_valid_r  <= '0;
         done_data_r   <= '0;
         err_unknown_r <= 1'b0;
      end else begin
         done_valid_r  <= rsp_hit_s;
         err_unknown_r <= rsp_valid & ~(|rsp_hit_s);
         if (|rsp_hit_s) begin
            done_data_r <= rsp_data;
         end else begin
            done_data_r <= done_data_r;
         end
      end
   end

   assign req_ready   = req_ready_r;
   assign out_valid   = out_valid_r;
   assign out_ifinst  = out_ifinst_r;
   assign out_method  = out_method_r;
   assign out_call_id = out_call_id_r;
   assign out_params  = out_params_r;
   assign done_valid  = done_valid_r;
   assign done_data   = done_data_r;
   assign busy        = busy_r;
   assign err_unknown = err_unknown_r;

endmodule

// File: tb/tb_tblink_rpc_invoke_sched.sv
// Bench for tblink_rpc_invoke_sched: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_tblink_rpc_invoke_sched;

   localparam int N  = 4;
   localparam int MW = 16;
   localparam int DW = 64;
   localparam int IW = 8;

   logic              clock = 1'b0;
   logic              reset;
   logic [N-1:0]      req_valid, req_ready, req_blocking;
   logic [N*MW-1:0]   req_method;
   logic [N*DW-1:0]   req_params;
   logic              out_valid, out_ready;
   logic [1:0]        out_ifinst;
   logic [MW-1:0]     out_method;
   logic [IW-1:0]     out_call_id;
   logic [DW-1:0]     out_params;
   logic              rsp_valid;
   logic [IW-1:0]     rsp_call_id;
   logic [DW-1:0]     rsp_data;
   logic [N-1:0]      done_valid, busy;
   logic [DW-1:0]     done_data;
   logic              err_unknown;

   logic [MW-1:0]     tb_meth [N];
   logic [DW-1:0]     tb_par  [N];

   for (genvar g = 0; g < N; g++) begin : g_pack
      assign req_method[g*MW +: MW] = tb_meth[g];
      assign req_params[g*DW +: DW] = tb_par[g];
   end

   always #5 clock = ~clock;

   tblink_rpc_invoke_sched #(
      .N_REQ(N), .METHOD_W(MW), .DATA_W(DW), .ID_W(IW)
   ) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_blocking(req_blocking),
      .req_method(req_method), .req_params(req_params),
      .out_valid(out_valid), .out_ready(out_ready), .out_ifinst(out_ifinst),
      .out_method(out_method), .out_call_id(out_call_id), .out_params(out_params),
      .rsp_valid(rsp_valid), .rsp_call_id(rsp_call_id), .rsp_data(rsp_data),
      .done_valid(done_valid), .done_data(done_data), .busy(busy),
      .err_unknown(err_unknown)
   );

   // ---------------- reference model state ----------------
   bit            m_busy [N];
   int            m_id   [N];
   int            m_cnt, m_ptr;
   bit            m_iss;          // an invoke is being offered on out_*
   int            c_idx, c_id;
   bit            c_blk;
   logic [MW-1:0] c_meth;
   logic [DW-1:0] c_par;
   logic          e_ov, e_err;
   logic [N-1:0]  e_rr, e_dv, e_busy;
   logic [DW-1:0] e_dd;

   int n_pass = 0, n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply the scheduler's rules to the inputs present at this clock edge.
   task automatic model_edge();
      bit old_busy [N];
      int old_id   [N];
      bit elig     [N];
      bit any_el, clash;
      int hit, w;
      e_rr = '0; e_dv = '0; e_err = 1'b0;
      if (reset) begin
         for (int i = 0; i < N; i++) begin m_busy[i] = 0; m_id[i] = 0; end
         m_cnt = 0; m_ptr = 0; m_iss = 0;
      end else begin
         old_busy = m_busy;
         old_id   = m_id;
         if (rsp_valid) begin
            hit = -1;
            for (int i = 0; i < N; i++)
               if (hit < 0 && old_busy[i] && old_id[i] == int'(rsp_call_id)) hit = i;
            if (hit >= 0) begin
               e_dv[hit] = 1'b1; e_dd = rsp_data; m_busy[hit] = 0;
            end else begin
               e_err = 1'b1;
            end
         end
         if (m_iss) begin
            if (out_ready) begin
               if (c_blk) begin m_busy[c_idx] = 1; m_id[c_idx] = c_id; end
               m_iss = 0;
            end
         end else begin
            any_el = 0; clash = 0;
            for (int i = 0; i < N; i++) begin
               elig[i] = req_valid[i] && !old_busy[i];
               any_el |= elig[i];
               clash  |= old_busy[i] && (old_id[i] == m_cnt);
            end
            if (any_el) begin
               if (clash) begin
                  m_cnt = (m_cnt + 1) % (1 << IW);
               end else begin
                  w = -1;
                  for (int k = 0; k < N; k++)
                     if (w < 0 && elig[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                  c_idx = w; c_blk = req_blocking[w]; c_meth = tb_meth[w]; c_par = tb_par[w];
                  c_id  = m_cnt;
                  m_cnt = (m_cnt + 1) % (1 << IW);
                  m_ptr = (w + 1) % N;
                  m_iss = 1;
                  e_rr[w] = 1'b1;
               end
            end
         end
      end
      e_ov = m_iss;
      for (int i = 0; i < N; i++) e_busy[i] = m_busy[i];
   endtask

   task automatic check_all();
      chk("out_valid", 64'(out_valid), 64'(e_ov));
      chk("req_ready", 64'(req_ready), 64'(e_rr));
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done_valid", 64'(done_valid), 64'(e_dv));
      chk("err_unknown", 64'(err_unknown), 64'(e_err));
      if (e_ov) begin
         chk("out_ifinst", 64'(out_ifinst), 64'(c_idx));
         chk("out_method", 64'(out_method), 64'(c_meth));
         chk("out_call_id", 64'(out_call_id), 64'(c_id));
         chk("out_params", out_params, c_par);
      end
      if (e_dv != '0) chk("done_data", done_data, e_dd);
   endtask

   // One clock: model the edge, then compare shortly after it.
   task automatic cycle();
      @(posedge clock);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic idle_inputs();
      req_valid = '0; req_blocking = '0; out_ready = 1'b1;
      rsp_valid = 1'b0; rsp_call_id = '0; rsp_data = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1; cycle(); cycle(); reset = 1'b0;
   endtask

   int cap_idx [$];
   int cap_id  [$];
   int prev_id, last_cap, gap, cyc;
   bit seen;
   int old0;

   initial begin
      for (int i = 0; i < N; i++) begin tb_meth[i] = '0; tb_par[i] = '0; end
      idle_inputs();
      do_reset();

      // 1: single blocking call and its response
      tb_meth[0] = 16'h0012; tb_par[0] = 64'd5;
      req_valid[0] = 1'b1; req_blocking[0] = 1'b1;
      cycle();
      chk("t1_out_valid", 64'(out_valid), 64'd1);
      chk("t1_call_id", 64'(out_call_id), 64'd0);
      chk("t1_ifinst", 64'(out_ifinst), 64'd0);
      req_valid = '0;
      cycle();
      rsp_valid = 1'b1; rsp_call_id = 8'd0; rsp_data = 64'hAB;
      cycle();
      chk("t1_done_valid", 64'(done_valid), 64'h1);
      chk("t1_done_data", done_data, 64'hAB);
      rsp_valid = 1'b0;
      cycle();
      chk("t1_busy", 64'(busy), 64'd0);

      // 2: all requesters, blocking, immediate responses
      do_reset();
      for (int i = 0; i < N; i++) tb_meth[i] = MW'(16'h0100 + i);
      req_valid = 4'b1111; req_blocking = 4'b1111;
      for (int t = 0; t < 40 && cap_idx.size() < 5; t++) begin
         rsp_valid = 1'b0;
         for (int i = 0; i < N; i++)
            if (!rsp_valid && m_busy[i]) begin
               rsp_valid = 1'b1; rsp_call_id = IW'(m_id[i]); rsp_data = 64'(t);
            end
         cycle();
         if (req_ready != '0) begin cap_idx.push_back(int'(out_ifinst)); cap_id.push_back(int'(out_call_id)); end
      end
      chk("t2_count", 64'(cap_idx.size()), 64'd5);
      if (cap_idx.size() == 5) begin
         for (int k = 0; k < 5; k++) begin
            chk("t2_grant", 64'(cap_idx[k]), 64'(k % N));
            chk("t2_id", 64'(cap_id[k]), 64'(k));
         end
      end
      idle_inputs();
      cycle();

      // 4: non-blocking from 2, then a response with its id
      do_reset();
      req_valid[2] = 1'b1; req_blocking[2] = 1'b0;
      cycle();
      req_valid = '0;
      cycle();
      rsp_valid = 1'b1; rsp_call_id = IW'(c_id); rsp_data = 64'h55;
      cycle();
      chk("t4_err", 64'(err_unknown), 64'd1);
      chk("t4_done", 64'(done_valid), 64'd0);
      chk("t4_busy", 64'(busy), 64'd0);
      rsp_valid = 1'b0;
      cycle();
      chk("t4_err_once", 64'(err_unknown), 64'd0);

      // 5: counter wrap with call id 0 still outstanding
      do_reset();
      req_valid[0] = 1'b1; req_blocking[0] = 1'b1;
      cycle();
      req_valid = '0;
      cycle();
      req_valid[1] = 1'b1; req_blocking[1] = 1'b0;
      prev_id = -1; last_cap = 0; seen = 0;
      for (cyc = 0; cyc < 700 && !seen; cyc++) begin
         cycle();
         if (e_rr != '0) begin
            if (prev_id == 255) begin
               gap = cyc - last_cap;
               chk("t5_id_after_wrap", 64'(out_call_id), 64'd1);
               chk("t5_stall_gap", 64'(gap), 64'd3);
               seen = 1;
            end
            prev_id = c_id; last_cap = cyc;
         end
      end
      chk("t5_wrap_seen", 64'(seen), 64'd1);
      req_valid = '0;
      cycle();

      // 6: reset during ISSUE with two calls outstanding
      req_valid[2] = 1'b1; req_blocking[2] = 1'b1;
      cycle();
      req_valid = '0;
      cycle();
      old0 = m_id[0];
      req_valid[3] = 1'b1; req_blocking[3] = 1'b1; out_ready = 1'b0;
      cycle();
      cycle();
      chk("t6_outstanding", 64'(busy), 64'b0101);
      req_valid = '0; reset = 1'b1;
      cycle();
      chk("t6_out_valid", 64'(out_valid), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      reset = 1'b0; out_ready = 1'b1;
      rsp_valid = 1'b1; rsp_call_id = IW'(old0); rsp_data = 64'h77;
      cycle();
      chk("t6_stale_err", 64'(err_unknown), 64'd1);
      rsp_valid = 1'b0;
      cycle();

      // random traffic, including busy requesters re-requesting
      for (int t = 0; t < 400; t++) begin
         reset        = ($urandom_range(0, 99) == 0);
         req_valid    = N'($urandom_range(0, 15));
         req_blocking = N'($urandom_range(0, 15));
         for (int i = 0; i < N; i++) begin
            tb_meth[i] = MW'($urandom);
            tb_par[i]  = {$urandom, $urandom};
         end
         out_ready = ($urandom_range(0, 3) != 0);
         rsp_valid = ($urandom_range(0, 2) == 0);
         rsp_data  = {$urandom, $urandom};
         begin
            int r;
            r = $urandom_range(0, N - 1);
            if (m_busy[r] && $urandom_range(0, 3) != 0) rsp_call_id = IW'(m_id[r]);
            else rsp_call_id = IW'($urandom_range(0, 255));
         end
         cycle();
      end
      reset = 1'b0;
      idle_inputs();
      cycle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
